// File: rtl/clkgen_multi.sv
// Lock-qualified reset sequencer and multi-channel fractional clock-enable generator.
// Runs entirely in the refclk domain directly behind the system PLL.
module clkgen_multi #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_FILTER = 1024,
    parameter int RELEASE_GAP = 16,
    parameter logic [ACC_W-1:0] INCR_DEFAULT = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic                                        refclk,
    input  logic                                        rst_n,
    input  logic                                        pll_locked_i,
    input  logic                                        cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]                            cfg_incr,
    output logic                                        locked_o,
    output logic [2:0]                                  state_o,
    output logic [NUM_CH-1:0]                           rst_out_n,
    output logic [NUM_CH-1:0]                           clken_o
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FILT_W = $clog2(LOCK_FILTER);
    localparam int GAP_W  = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILTER - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(RELEASE_GAP - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3
    } state_e;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              lk_s;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              filt_ok;
    state_e            state_q, state_d;
    logic              locked_q, locked_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [NUM_CH-1:0] rst_out_q, rst_out_d;
    logic [NUM_CH-1:0] clken_q, clken_d;
    logic [ACC_W-1:0]  acc_q  [NUM_CH];
    logic [ACC_W-1:0]  acc_d  [NUM_CH];
    logic [ACC_W-1:0]  incr_q [NUM_CH];
    logic [ACC_W-1:0]  incr_d [NUM_CH];
    logic [ACC_W:0]    sum;

    // The raw lock is asynchronous; everything downstream only ever sees lk_s.
    always_comb begin
        sync1_d = pll_locked_i;
        sync2_d = sync1_q;
        lk_s    = sync2_q;
        filt_ok = (filt_cnt_q == FILT_MAX);
        if (!lk_s) begin
            filt_cnt_d = '0;
        end else if (filt_ok) begin
            filt_cnt_d = filt_cnt_q;
        end else begin
            filt_cnt_d = filt_cnt_q + FILT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        locked_d  = locked_q;
        gap_d     = gap_q;
        rst_out_d = rst_out_q;
        if (!lk_s) begin
            state_d   = WAIT_LOCK;
            locked_d  = 1'b0;
            gap_d     = '0;
            rst_out_d = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (filt_ok) begin
                        state_d   = RELEASE;
                        locked_d  = 1'b1;
                        gap_d     = '0;
                        rst_out_d = NUM_CH'(1);
                    end
                end
                RELEASE: begin
                    // Releases fill in from bit 0 upward, so the top bit marks completion.
                    if (rst_out_q[NUM_CH-1]) begin
                        state_d = RUN;
                    end else if (gap_q == GAP_MAX) begin
                        gap_d     = '0;
                        rst_out_d = (rst_out_q << 1) | NUM_CH'(1);
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d   = WAIT_LOCK;
                    locked_d  = 1'b0;
                    gap_d     = '0;
                    rst_out_d = '0;
                end
            endcase
        end
    end

    // Carry out of the accumulator is the enable, registered so it lands one cycle later.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, acc_q[k]} + {1'b0, incr_q[k]};
            if (!lk_s || !rst_out_q[k]) begin
                acc_d[k]   = '0;
                clken_d[k] = 1'b0;
            end else begin
                acc_d[k]   = sum[ACC_W-1:0];
                clken_d[k] = sum[ACC_W];
            end
            incr_d[k] = (cfg_we && (cfg_ch == CH_W'(k))) ? cfg_incr : incr_q[k];
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            filt_cnt_q <= '0;
            state_q    <= WAIT_LOCK;
            locked_q   <= 1'b0;
            gap_q      <= '0;
            rst_out_q  <= '0;
            clken_q    <= '0;
            acc_q      <= '{default: '0};
            incr_q     <= '{default: INCR_DEFAULT};
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            locked_q   <= locked_d;
            gap_q      <= gap_d;
            rst_out_q  <= rst_out_d;
            clken_q    <= clken_d;
            acc_q      <= acc_d;
            incr_q     <= incr_d;
        end
    end

    assign locked_o  = locked_q;
    assign state_o   = state_q;
    assign rst_out_n = rst_out_q;
    assign clken_o   = clken_q;

endmodule

// File: tb/tb_clkgen_multi.sv
// Randomised bench for clkgen_multi, checked every cycle against a timeline-based model
// (cycles since lock declared, run length of good lock samples, integer accumulators).
module tb_clkgen_multi;

    localparam int NUM_CH      = 4;
    localparam int ACC_W       = 8;
    localparam int LOCK_FILTER = 8;
    localparam int RELEASE_GAP = 4;
    localparam int INCR_DEF    = 128;
    localparam int MODULUS     = 256;

    logic                 refclk = 1'b0;
    logic                 rst_n;
    logic                 pll_locked_i;
    logic                 cfg_we;
    logic [1:0]           cfg_ch;
    logic [ACC_W-1:0]     cfg_incr;
    logic                 locked_o;
    logic [2:0]           state_o;
    logic [NUM_CH-1:0]    rst_out_n;
    logic [NUM_CH-1:0]    clken_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_s1, m_s2, m_locked;
    int          m_run, m_t, m_state;
    bit [3:0]    m_rst, m_clk;
    int          m_acc  [NUM_CH];
    int          m_incr [NUM_CH];

    always #5 refclk = ~refclk;

    clkgen_multi #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_FILTER(LOCK_FILTER),
        .RELEASE_GAP(RELEASE_GAP), .INCR_DEFAULT(8'd128)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked_i(pll_locked_i),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_incr(cfg_incr),
        .locked_o(locked_o), .state_o(state_o),
        .rst_out_n(rst_out_n), .clken_o(clken_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
        end
    endtask

    // One refclk edge of the model, from the rules: lock after LOCK_FILTER good samples,
    // channel k out of reset k*RELEASE_GAP cycles after lock, enables from integer overflow.
    task automatic model_edge(input bit rstn, input bit pll, input bit we,
                              input int ch, input int incr);
        bit       old_lk;
        bit [3:0] old_rst;
        int       sum;
        if (!rstn) begin
            m_s1 = 0; m_s2 = 0; m_locked = 0; m_run = 0; m_t = 0; m_state = 1;
            m_rst = '0; m_clk = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_acc[k]  = 0;
                m_incr[k] = INCR_DEF;
            end
            return;
        end
        old_lk  = m_s2;
        old_rst = m_rst;
        m_s2 = m_s1;
        m_s1 = pll;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!old_lk || !old_rst[k]) begin
                m_acc[k] = 0;
                m_clk[k] = 0;
            end else begin
                sum      = m_acc[k] + m_incr[k];
                m_acc[k] = sum % MODULUS;
                m_clk[k] = (sum >= MODULUS);
            end
        end
        if (we && ch < NUM_CH) m_incr[ch] = incr;
        if (!old_lk) begin
            m_run = 0; m_locked = 0; m_t = 0;
        end else begin
            if (m_locked) begin
                if (m_t < 1000) m_t++;
            end else if (m_run == LOCK_FILTER - 1) begin
                m_locked = 1;
                m_t = 0;
            end
            if (m_run < LOCK_FILTER - 1) m_run++;
        end
        for (int k = 0; k < NUM_CH; k++) m_rst[k] = m_locked && (m_t >= k * RELEASE_GAP);
        if (!m_locked)                               m_state = 1;
        else if (m_t > (NUM_CH - 1) * RELEASE_GAP)   m_state = 3;
        else                                         m_state = 2;
    endtask

    task automatic applyStimulus(input bit rstn, input bit pll, input bit we,
                                 input int ch, input int incr);
        rst_n        = rstn;
        pll_locked_i = pll;
        cfg_we       = we;
        cfg_ch       = 2'(ch);
        cfg_incr     = 8'(incr);
        @(posedge refclk);
        model_edge(rstn, pll, we, ch, incr);
        #1;
        checkOutput("locked_o", 32'(locked_o), 32'(m_locked));
        checkOutput("state_o", 32'(state_o), 32'(m_state));
        checkOutput("rst_out_n", 32'(rst_out_n), 32'(m_rst));
        checkOutput("clken_o", 32'(clken_o), 32'(m_clk));
    endtask

    int first_lock, first_run, pulses2, pulses3, pulses0, drop_len;
    bit pll_r, we_r;

    initial begin
        rst_n = 0; pll_locked_i = 0; cfg_we = 0; cfg_ch = '0; cfg_incr = '0;

        // Reset, then lock applied from the first post-reset edge
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        first_lock = -1;
        first_run  = -1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            if (first_lock < 0 && locked_o) first_lock = i;
            if (first_run < 0 && state_o == 3'd3) first_run = i;
        end
        checkOutput("lock_latency", 32'(first_lock), 32'd9);
        checkOutput("run_latency", 32'(first_run), 32'd22);

        // Reprogram channel 2 to quarter rate and silence channel 3
        applyStimulus(1, 1, 1, 2, 64);
        applyStimulus(1, 1, 1, 3, 0);
        pulses2 = 0;
        pulses3 = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            pulses2 += int'(clken_o[2]);
            pulses3 += int'(clken_o[3]);
        end
        checkOutput("ch2_quarter_rate", 32'(pulses2), 32'd10);
        checkOutput("ch3_zero_rate", 32'(pulses3), 32'd0);

        // Extreme incrementer on channel 1: 39 pulses in 40 additions of 255 at most
        applyStimulus(1, 1, 1, 1, 255);
        repeat (20) applyStimulus(1, 1, 0, 0, 0);

        // One-cycle lock glitch while the filter count is 5
        repeat (2) applyStimulus(0, 0, 0, 0, 0);
        first_lock = -1;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1, (i != 5), 0, 0, 0);
            if (first_lock < 0 && locked_o) first_lock = i;
        end
        checkOutput("glitch_relock", 32'(first_lock), 32'd15);

        // Lock drop in RUN, then relock replays the release sequence
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        repeat (30) applyStimulus(1, 1, 0, 0, 0);

        // Reset mid-RELEASE after a write; defaults must come back
        repeat (2) applyStimulus(0, 0, 0, 0, 0);
        repeat (14) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        repeat (30) applyStimulus(1, 1, 0, 0, 0);
        pulses0 = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            pulses0 += int'(clken_o[0]);
        end
        checkOutput("ch0_default_after_reset", 32'(pulses0), 32'd10);

        // Random lock drops, config writes and occasional resets
        drop_len = 0;
        for (int i = 0; i < 1500; i++) begin
            if (drop_len == 0 && $urandom_range(0, 59) == 0) drop_len = $urandom_range(1, 4);
            pll_r = (drop_len == 0);
            if (drop_len > 0) drop_len--;
            we_r = ($urandom_range(0, 7) == 0);
            applyStimulus(($urandom_range(0, 299) != 0), pll_r, we_r,
                          $urandom_range(0, NUM_CH - 1), $urandom_range(0, 255));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
